pc_gen_unit: RTL and testbench
==============================

# pc_gen_unit

Fetch-stage program-counter generator for the pipelined CPU: it owns the PC register and selects the next PC from sequential, branch, jump, jump-register, trap and exception-return sources. It generalises the combinational next-PC mux with parametrised address width, instruction size and trap vector. It adds a deferred-redirect latch for fetch-side stalls, misaligned-target detection and EPC/cause capture. Redirect requests come from EX; `pc` drives instruction fetch.

## Interface
- ADDR_W, 32, PC/address width
- INSTR_BYTES, 4, instruction size (power of two); sequential increment and alignment granule
- RESET_PC, 32'h0000_3000, PC value on reset
- TRAP_VEC, 32'h0000_4180, trap handler entry
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_stall  in  1  IF cannot accept a new PC; EX keeps advancing
- npc_op  in  3  0 SEQ, 1 BRANCH, 2 J, 3 JR, 4 TRAP, 5 ERET, 6–7 treated as SEQ
- zero  in  1  branch condition for BRANCH
- branch_addr / jump_addr / rd0  in  ADDR_W  targets for BRANCH / J / JR
- ex_pc  in  ADDR_W  PC of the EX instruction, captured into EPC on a trap
- trap_req  in  1  external exception request, same priority as op TRAP
- pc  out  ADDR_W  current fetch PC (register)
- epc  out  ADDR_W  exception PC (register)
- cause  out  2  0 none, 1 external/op trap, 2 misaligned target (register)
- pending  out  1  a redirect is latched, waiting for fetch_stall to drop
- flush  out  1  combinational; kill IF/ID this cycle

## Operation
- Redirect request priority, highest first: trap_req or op TRAP; misaligned target; BRANCH with zero=1, J, JR, ERET. Otherwise no redirect.
- Misaligned target: BRANCH-taken, J or JR target with any of the low log2(INSTR_BYTES) bits set. The request becomes a trap with cause=2. ERET targets are not checked.
- Trap: the redirect target is TRAP_VEC. epc ← ex_pc. cause ← 1 or 2.
- ERET: the redirect target is the current epc; cause ← 0.
- Non-trap redirects while pending=1 are ignored; they come from a flushed path. A trap while pending=1 overwrites the latched target and still captures epc/cause.
- Per cycle, with fetch_stall=0:
  - pc ← accepted redirect target, else the pending target (pending clears), else pc + INSTR_BYTES.
  - Sums wrap modulo 2^ADDR_W.
- Per cycle, with fetch_stall=1:
  - pc holds.
  - An accepted redirect loads the pending target and sets pending.
  - epc/cause update immediately on a trap.
- flush = an accepted redirect this cycle, or (pending and not fetch_stall).
- Reset values: pc=RESET_PC, epc=0, cause=0, pending=0, pending target=0. flush is forced 0 while rst=1.

## Timing
- One-cycle redirect latency: a request in cycle n gives pc = target in cycle n+1 when not stalled.
- A deferred redirect is applied on the first edge with fetch_stall=0. pc changes one cycle after stall drops.
- The EX redirect is a single-cycle pulse. The block never requires it to be held.
- Simultaneous stall release and a new non-trap redirect while pending=1: the pending target wins and the new request is ignored. A trap in that cycle wins over both.
- rst asserted mid-operation clears all state asynchronously. The first post-reset fetch is at RESET_PC.

## Structure
- Shared package `cpu_pkg`:
  - npc_op encodings (NPC_SEQ … NPC_ERET)
  - cause codes (CAUSE_NONE, CAUSE_TRAP, CAUSE_MISALIGN)
  - default RESET_PC and TRAP_VEC constants
- One combinational sub-module, `pc_redirect_sel`, produces request valid, target, is_trap and cause from op/zero/addresses/epc.
- The top holds the pc, epc, cause and pending registers.

## Test plan
- Reset then free-run, no stall: pc = 0x3000, 0x3004, 0x3008; flush=0; epc=0; cause=0.
- At pc=0x3008, BRANCH, zero=1, branch_addr=0x3040: flush=1, next pc=0x3040. Repeat with zero=0: next pc=0x300C.
- fetch_stall=1 with J jump_addr=0x3100:
  - pc holds, pending=1.
  - JR next cycle is ignored.
  - Stall drops: flush=1, pc=0x3100, pending=0.
- JR rd0=0x3102, ex_pc=0x3020: pc=0x4180, epc=0x3020, cause=2.
- trap_req with ex_pc=0x3010: pc=0x4180, epc=0x3010, cause=1. Then ERET: pc=0x3010, cause=0.
- Pending set under stall, then rst pulsed asynchronously mid-cycle: pending=0 and pc=0x3000 immediately. After release, sequential fetch resumes from 0x3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch-stage PC generator.
//   npc_op_e : next-PC source select driven by EX (3 bits; 6-7 behave as SEQ)
//   cause_e  : exception cause codes held in the cause register
//   RESET_PC_DEF / TRAP_VEC_DEF : default reset PC and trap handler entry
package cpu_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_J      = 3'd2,
    NPC_JR     = 3'd3,
    NPC_TRAP   = 3'd4,
    NPC_ERET   = 3'd5
  } npc_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TRAP     = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_4180;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational redirect selector.
// Decodes the EX redirect request into a single candidate redirect.
//   npc_op_i      : next-PC operation (cpu_pkg::npc_op_e encoding)
//   zero_i        : branch condition for BRANCH
//   trap_req_i    : external exception request
//   branch_addr_i / jump_addr_i / rd0_i : BRANCH / J / JR targets
//   epc_i         : current exception PC (ERET target)
//   req_valid_o   : a redirect is requested this cycle
//   target_o      : redirect target
//   is_trap_o     : the redirect is a trap (captures epc/cause)
//   is_eret_o     : the redirect is an exception return (clears cause)
//   cause_o       : cause code to record on a trap
module pc_redirect_sel
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0]  TRAP_VEC    = ADDR_W'(TRAP_VEC_DEF)
) (
  input  logic [2:0]        npc_op_i,
  input  logic              zero_i,
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [ADDR_W-1:0] rd0_i,
  input  logic [ADDR_W-1:0] epc_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              is_trap_o,
  output logic              is_eret_o,
  output logic [1:0]        cause_o
);

  // Low address bits that must be zero for an instruction-aligned target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  logic              cand_valid;
  logic              cand_checked;
  logic [ADDR_W-1:0] cand_target;

  always_comb begin
    cand_valid   = 1'b0;
    cand_checked = 1'b0;
    cand_target  = '0;
    case (npc_op_i)
      NPC_BRANCH: begin
        cand_valid   = zero_i;
        cand_checked = 1'b1;
        cand_target  = branch_addr_i;
      end
      NPC_J: begin
        cand_valid   = 1'b1;
        cand_checked = 1'b1;
        cand_target  = jump_addr_i;
      end
      NPC_JR: begin
        cand_valid   = 1'b1;
        cand_checked = 1'b1;
        cand_target  = rd0_i;
      end
      NPC_ERET: begin
        cand_valid  = 1'b1;
        cand_target = epc_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_valid_o = 1'b0;
    target_o    = '0;
    is_trap_o   = 1'b0;
    is_eret_o   = 1'b0;
    cause_o     = CAUSE_NONE;
    if (trap_req_i || (npc_op_i == NPC_TRAP)) begin
      req_valid_o = 1'b1;
      target_o    = TRAP_VEC;
      is_trap_o   = 1'b1;
      cause_o     = CAUSE_TRAP;
    end else if (cand_valid && cand_checked && ((cand_target & ALIGN_MASK) != '0)) begin
      req_valid_o = 1'b1;
      target_o    = TRAP_VEC;
      is_trap_o   = 1'b1;
      cause_o     = CAUSE_MISALIGN;
    end else if (cand_valid) begin
      req_valid_o = 1'b1;
      target_o    = cand_target;
      is_eret_o   = (npc_op_i == NPC_ERET);
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator.
// Owns the fetch PC and the EPC/cause registers, and defers redirects that
// arrive while IF is stalled until the stall drops.
//   clk, rst          : clock (rising edge), async active-high reset
//   fetch_stall       : IF cannot take a new PC this cycle
//   npc_op, zero      : next-PC operation and branch condition from EX
//   branch_addr, jump_addr, rd0 : BRANCH / J / JR targets
//   ex_pc             : PC of the EX instruction, saved into epc on a trap
//   trap_req          : external exception request
//   pc, epc, cause    : fetch PC, exception PC, exception cause (registers)
//   pending           : a redirect is latched awaiting stall release
//   flush             : kill IF/ID this cycle (combinational)
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0]  TRAP_VEC    = ADDR_W'(TRAP_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_stall,
  input  logic [2:0]        npc_op,
  input  logic              zero,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [ADDR_W-1:0] rd0,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              trap_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        cause,
  output logic              pending,
  output logic              flush
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] ptgt_q, ptgt_d;

  logic              req_valid;
  logic [ADDR_W-1:0] req_target;
  logic              req_is_trap;
  logic              req_is_eret;
  logic [1:0]        req_cause;
  logic              accepted;

  pc_redirect_sel #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES),
    .TRAP_VEC    (TRAP_VEC)
  ) u_sel (
    .npc_op_i      (npc_op),
    .zero_i        (zero),
    .trap_req_i    (trap_req),
    .branch_addr_i (branch_addr),
    .jump_addr_i   (jump_addr),
    .rd0_i         (rd0),
    .epc_i         (epc_q),
    .req_valid_o   (req_valid),
    .target_o      (req_target),
    .is_trap_o     (req_is_trap),
    .is_eret_o     (req_is_eret),
    .cause_o       (req_cause)
  );

  // While a redirect is latched, younger non-trap requests come from a
  // flushed path; only traps may replace it.
  assign accepted = req_valid && (!pending_q || req_is_trap);

  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    pending_d = pending_q;
    ptgt_d    = ptgt_q;

    if (fetch_stall) begin
      if (accepted) begin
        pending_d = 1'b1;
        ptgt_d    = req_target;
      end
    end else begin
      pending_d = 1'b0;
      if (accepted)       pc_d = req_target;
      else if (pending_q) pc_d = ptgt_q;
      else                pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end

    if (accepted && req_is_trap) begin
      epc_d   = ex_pc;
      cause_d = req_cause;
    end else if (accepted && req_is_eret) begin
      cause_d = CAUSE_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      cause_q   <= CAUSE_NONE;
      pending_q <= 1'b0;
      ptgt_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      ptgt_q    <= ptgt_d;
    end
  end

  assign flush   = !rst && (accepted || (pending_q && !fetch_stall));
  assign pc      = pc_q;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_stall;
  logic [2:0]  npc_op;
  logic        zero;
  logic [31:0] branch_addr, jump_addr, rd0, ex_pc;
  logic        trap_req;
  logic [31:0] pc, epc;
  logic [1:0]  cause;
  logic        pending, flush;

  always #5 clk = ~clk;

  pc_gen_unit #(
    .ADDR_W      (32),
    .INSTR_BYTES (4),
    .RESET_PC    (32'h0000_3000),
    .TRAP_VEC    (32'h0000_4180)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_stall (fetch_stall),
    .npc_op      (npc_op),
    .zero        (zero),
    .branch_addr (branch_addr),
    .jump_addr   (jump_addr),
    .rd0         (rd0),
    .ex_pc       (ex_pc),
    .trap_req    (trap_req),
    .pc          (pc),
    .epc         (epc),
    .cause       (cause),
    .pending     (pending),
    .flush       (flush)
  );

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, J = 3'd2, JR = 3'd3, TRP = 3'd4, ERET = 3'd5;

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic        z;
    logic [31:0] ba, ja, rd, xp;
    logic        trp, stl;
    logic        xflush;
    logic [31:0] xpc, xepc;
    logic [1:0]  xcause;
    logic        xpend;
  } vec_t;

  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string tag, logic [2:0] op, logic z, logic [31:0] ba,
                              logic [31:0] ja, logic [31:0] rd, logic [31:0] xp,
                              logic trp, logic stl, logic xflush, logic [31:0] xpc,
                              logic [31:0] xepc, logic [1:0] xcause, logic xpend);
    vec_t v;
    v.tag = tag; v.op = op; v.z = z; v.ba = ba; v.ja = ja; v.rd = rd; v.xp = xp;
    v.trp = trp; v.stl = stl; v.xflush = xflush; v.xpc = xpc; v.xepc = xepc;
    v.xcause = xcause; v.xpend = xpend;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    npc_op = v.op; zero = v.z; branch_addr = v.ba; jump_addr = v.ja;
    rd0 = v.rd; ex_pc = v.xp; trap_req = v.trp; fetch_stall = v.stl;
  endtask

  task automatic idle();
    npc_op = SEQ; zero = 1'b0; branch_addr = '0; jump_addr = '0;
    rd0 = '0; ex_pc = '0; trap_req = 1'b0; fetch_stall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #12;
    vectors++;
    if ({pc, epc, cause, pending, flush} !== {32'h3000, 32'h0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: pc=%h epc=%h cause=%0d pending=%b flush=%b, want 3000/0/0/0/0",
               pc, epc, cause, pending, flush);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_table(input vec_t v[$]);
    vec_t e;
    foreach (v[i]) begin
      drive(v[i]);
      sb.push_back(v[i]);
      #1;
      vectors++;
      if (flush !== v[i].xflush) begin
        miscompares++;
        $display("FAIL %s.flush: got %b want %b", v[i].tag, flush, v[i].xflush);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({pc, epc, cause, pending} !== {e.xpc, e.xepc, e.xcause, e.xpend}) begin
        miscompares++;
        $display("FAIL %s: pc=%h epc=%h cause=%0d pending=%b, want pc=%h epc=%h cause=%0d pending=%b",
                 e.tag, pc, epc, cause, pending, e.xpc, e.xepc, e.xcause, e.xpend);
      end
    end
  endtask

  task automatic test_seq();
    vec_t v[$];
    v.push_back(mk("seq0", SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
    v.push_back(mk("seq1", SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
    run_table(v);
  endtask

  task automatic test_branch();
    vec_t v[$];
    v.push_back(mk("br_taken", BR, 1, 32'h3040, 0, 0, 0, 0, 0, 1, 32'h3040, 0, 0, 0));
    v.push_back(mk("br_not",   BR, 0, 32'h3080, 0, 0, 0, 0, 0, 0, 32'h3044, 0, 0, 0));
    v.push_back(mk("op7_seq",  3'd7, 1, 32'h5000, 32'h5000, 32'h5000, 0, 0, 0, 0, 32'h3048, 0, 0, 0));
    v.push_back(mk("op6_seq",  3'd6, 1, 32'h5000, 32'h5000, 32'h5000, 0, 0, 0, 0, 32'h304C, 0, 0, 0));
    run_table(v);
  endtask

  task automatic test_stall();
    vec_t v[$];
    v.push_back(mk("st_j",      J,   0, 0, 32'h3100, 0, 0, 0, 1, 1, 32'h304C, 0, 0, 1));
    v.push_back(mk("st_jr_ign", JR,  0, 0, 0, 32'h3200, 0, 0, 1, 0, 32'h304C, 0, 0, 1));
    v.push_back(mk("st_hold",   SEQ, 0, 0, 0, 0, 0, 0, 1, 0, 32'h304C, 0, 0, 1));
    v.push_back(mk("st_rel",    SEQ, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3100, 0, 0, 0));
    v.push_back(mk("st_after",  SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3104, 0, 0, 0));
    run_table(v);
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back(mk("b2b_j",    J,   0, 0, 32'h3300, 0, 0, 0, 1, 1, 32'h3104, 0, 0, 1));
    v.push_back(mk("b2b_rel",  BR,  1, 32'h3400, 0, 0, 0, 0, 0, 1, 32'h3300, 0, 0, 0));
    v.push_back(mk("b2b_seq",  SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3304, 0, 0, 0));
    run_table(v);
  endtask

  task automatic test_misalign();
    vec_t v[$];
    v.push_back(mk("mis_jr",   JR, 0, 0, 0, 32'h3102, 32'h3020, 0, 0, 1, 32'h4180, 32'h3020, 2, 0));
    v.push_back(mk("mis_brnt", BR, 0, 32'h3111, 0, 0, 32'h3024, 0, 0, 0, 32'h4184, 32'h3020, 2, 0));
    v.push_back(mk("mis_j",    J,  0, 0, 32'h3202, 0, 32'h3024, 0, 0, 1, 32'h4180, 32'h3024, 2, 0));
    v.push_back(mk("mis_br",   BR, 1, 32'h3201, 0, 0, 32'h3028, 0, 0, 1, 32'h4180, 32'h3028, 2, 0));
    run_table(v);
  endtask

  task automatic test_trap_eret();
    vec_t v[$];
    v.push_back(mk("trap_ext",  SEQ,  0, 0, 0, 0, 32'h3010, 1, 0, 1, 32'h4180, 32'h3010, 1, 0));
    v.push_back(mk("eret0",     ERET, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3010, 32'h3010, 0, 0));
    v.push_back(mk("trap_op",   TRP,  0, 0, 32'h3100, 0, 32'h3014, 0, 0, 1, 32'h4180, 32'h3014, 1, 0));
    v.push_back(mk("trap_seq",  SEQ,  0, 0, 0, 0, 0, 0, 0, 0, 32'h4184, 32'h3014, 1, 0));
    v.push_back(mk("eret1",     ERET, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3014, 32'h3014, 0, 0));
    v.push_back(mk("tp_pend",   J,    0, 0, 32'h3500, 0, 0, 0, 1, 1, 32'h3014, 32'h3014, 0, 1));
    v.push_back(mk("tp_over",   SEQ,  0, 0, 0, 0, 32'h3030, 1, 1, 1, 32'h3014, 32'h3030, 1, 1));
    v.push_back(mk("tp_rel",    SEQ,  0, 0, 0, 0, 0, 0, 0, 1, 32'h4180, 32'h3030, 1, 0));
    v.push_back(mk("tr_pend",   J,    0, 0, 32'h3600, 0, 0, 0, 1, 1, 32'h4180, 32'h3030, 1, 1));
    v.push_back(mk("tr_win",    SEQ,  0, 0, 0, 0, 32'h3034, 1, 0, 1, 32'h4180, 32'h3034, 1, 0));
    v.push_back(mk("tr_seq",    SEQ,  0, 0, 0, 0, 0, 0, 0, 0, 32'h4184, 32'h3034, 1, 0));
    run_table(v);
  endtask

  task automatic test_wrap();
    vec_t v[$];
    v.push_back(mk("wrap_j",  J,   0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h3034, 1, 0));
    v.push_back(mk("wrap_0",  SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h3034, 1, 0));
    v.push_back(mk("wrap_4",  SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 32'h3034, 1, 0));
    run_table(v);
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    vec_t w[$];
    v.push_back(mk("ar_pend", J, 0, 0, 32'h3700, 0, 0, 0, 1, 1, 32'h0000_0004, 32'h3034, 1, 1));
    run_table(v);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({pc, epc, cause, pending, flush} !== {32'h3000, 32'h0, 2'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_rst: pc=%h epc=%h cause=%0d pending=%b flush=%b, want 3000/0/0/0/0",
               pc, epc, cause, pending, flush);
    end
    idle();
    #1 rst = 1'b0;
    w.push_back(mk("ar_seq0", SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
    w.push_back(mk("ar_seq1", SEQ, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
    run_table(w);
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_stall();
    test_back_to_back();
    test_misalign();
    test_trap_eret();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule
